// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: datapath width, base opcodes, fetch FSM states.
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned OPCODE_W = 7;

   localparam logic [OPCODE_W-1:0] OP_IMM = 7'b0010011;
   localparam logic [OPCODE_W-1:0] LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP     = 7'b0110011;
   localparam logic [OPCODE_W-1:0] JAL    = 7'b1101111;
   localparam logic [OPCODE_W-1:0] STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] LUI    = 7'b0110111;
   localparam logic [OPCODE_W-1:0] BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_DISCARD = 2'd3
   } fetch_state_t;

   // Force an address onto a word boundary.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, keeps at most one read outstanding to
// instruction memory and holds one fetched instruction for decode.
module inst_fetch
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [XLEN-1:0]     imem_addr,
   input  logic                imem_ready,
   input  logic                imem_rvalid,
   input  logic [XLEN-1:0]     imem_rdata,
   output logic                inst_valid,
   output logic [XLEN-1:0]     inst,
   output logic [XLEN-1:0]     inst_pc,
   output logic [OPCODE_W-1:0] opcode,
   input  logic                inst_ready,
   input  logic                redirect,
   input  logic [XLEN-1:0]     redirect_pc
);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_addr;
   logic            handshake;
   logic            transfer;
   logic            unused_ok;

   // Low redirect bits are architecturally ignored.
   assign unused_ok = ^redirect_pc[1:0];

   // Request only when the buffer will have room at the next edge.
   always_comb begin
      imem_req  = (state == ST_FETCH) && (!inst_valid || inst_ready);
      imem_addr = pc;
      handshake = imem_req && imem_ready;
      transfer  = inst_valid && inst_ready;
      opcode    = inst[OPCODE_W-1:0];
   end

   // FSM, PC and output buffer; redirect overrides normal sequencing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         pc         <= RESET_PC;
         req_addr   <= '0;
         inst_valid <= 1'b0;
         inst       <= '0;
         inst_pc    <= '0;
      end else begin
         if (transfer) begin
            inst_valid <= 1'b0;
         end
         if (redirect) begin
            // An accepted or outstanding read must still be drained, so only
            // a withdrawn request or an arriving response skips DISCARD.
            inst_valid <= 1'b0;
            pc         <= word_align(redirect_pc);
            unique case (state)
               ST_FETCH:   state <= handshake   ? ST_DISCARD : ST_FETCH;
               ST_WAIT:    state <= imem_rvalid ? ST_FETCH   : ST_DISCARD;
               ST_DISCARD: state <= imem_rvalid ? ST_FETCH   : ST_DISCARD;
               default:    state <= ST_FETCH;
            endcase
         end else begin
            unique case (state)
               ST_IDLE: begin
                  state <= ST_FETCH;
               end
               ST_FETCH: begin
                  if (handshake) begin
                     req_addr <= pc;
                     state    <= ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (imem_rvalid) begin
                     inst       <= imem_rdata;
                     inst_pc    <= req_addr;
                     inst_valid <= 1'b1;
                     pc         <= pc + XLEN'(4);
                     state      <= ST_FETCH;
                  end
               end
               ST_DISCARD: begin
                  if (imem_rvalid) begin
                     state <= ST_FETCH;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory model with configurable latency,
// scoreboards for fetch addresses and delivered instructions.
module tb_inst_fetch;
   import riscv_pkg::*;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [6:0]  opcode;
   logic        inst_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   // second instance exercising PC wrap-around
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_rvalid;
   logic [31:0] w_rdata;
   logic        w_valid;
   logic [31:0] w_inst;
   logic [31:0] w_inst_pc;
   logic [6:0]  w_opcode;
   logic        w_one;
   logic        w_zero;
   logic [31:0] w_zero32;

   inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .opcode(opcode),
      .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc)
   );

   inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(rst),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_one),
      .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .inst_valid(w_valid), .inst(w_inst), .inst_pc(w_inst_pc), .opcode(w_opcode),
      .inst_ready(w_one), .redirect(w_zero), .redirect_pc(w_zero32)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } pend_t;

   exp_t        exp_q[$];
   logic [31:0] exp_addr[$];
   pend_t       pend[$];
   logic [31:0] wexp_addr[$];
   logic [31:0] wexp_pc[$];

   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned cyc = 0;
   int unsigned lat = 1;
   int unsigned xf_cnt = 0;
   int unsigned last_hs_cyc = 0;
   int unsigned last_xf_cyc = 0;
   int unsigned t0 = 0;
   logic [31:0] last_hs_addr = '1;

   logic        tb_rst = 1'b1;
   logic        tb_iready = 1'b0;
   logic        tb_mready = 1'b1;
   logic        tb_redir = 1'b0;
   logic [31:0] tb_rpc = '0;
   logic        w_pend = 1'b0;
   logic [31:0] w_pend_addr = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] memval(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h0010_0113;
      return {a[26:2], 7'b0110011} ^ 32'hA5A5_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic expect_inst(input logic [31:0] pc);
      exp_t e;
      e.pc = pc;
      e.word = memval(pc);
      exp_q.push_back(e);
   endtask

   // One clock cycle: drive inputs and memory responses at negedge, then
   // observe handshakes and transfers that complete at the next posedge.
   task automatic step();
      pend_t p;
      exp_t  e;
      @(negedge clk);
      cyc++;
      rst = tb_rst;
      inst_ready = tb_iready;
      imem_ready = tb_mready;
      redirect = tb_redir;
      redirect_pc = tb_rpc;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata = memval(pend[0].addr);
         void'(pend.pop_front());
      end
      w_rvalid = w_pend;
      w_rdata = memval(w_pend_addr);
      w_pend = 1'b0;
      if (tb_rst) pend.delete();
      #1;
      if (!tb_rst && imem_req && imem_ready) begin
         p.addr = imem_addr;
         p.due = cyc + lat;
         pend.push_back(p);
         last_hs_addr = imem_addr;
         last_hs_cyc = cyc;
         if (exp_addr.size() > 0) check("fetch_addr", imem_addr, exp_addr.pop_front());
      end
      if (!tb_rst && inst_valid && inst_ready) begin
         xf_cnt++;
         last_xf_cyc = cyc;
         check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("xfer_pc", inst_pc, e.pc);
            check("xfer_inst", inst, e.word);
            check("xfer_opcode", 32'(opcode), 32'(e.word[6:0]));
         end
      end
      if (!tb_rst && w_req) begin
         w_pend = 1'b1;
         w_pend_addr = w_addr;
         if (wexp_addr.size() > 0) check("wrap_addr", w_addr, wexp_addr.pop_front());
      end
      if (!tb_rst && w_valid && wexp_pc.size() > 0) begin
         check("wrap_inst_pc", w_inst_pc, wexp_pc.pop_front());
      end
   endtask

   task automatic do_reset();
      check("sb_inst_drain", exp_q.size(), 0);
      check("sb_addr_drain", exp_addr.size(), 0);
      exp_q.delete();
      exp_addr.delete();
      tb_rst = 1'b1;
      tb_redir = 1'b0;
      step();
      tb_rst = 1'b0;
      xf_cnt = 0;
      last_hs_addr = '1;
      step();
   endtask

   task automatic run_until_xfer(input string tag, input int unsigned n, input int unsigned budget);
      for (int unsigned i = 0; i < budget && xf_cnt < n; i++) step();
      check(tag, 32'(xf_cnt >= n), 32'd1);
   endtask

   task automatic run_until_hs_addr(input string tag, input logic [31:0] a, input int unsigned budget);
      for (int unsigned i = 0; i < budget && last_hs_addr != a; i++) step();
      check(tag, last_hs_addr, a);
   endtask

   initial begin
      rst = 1'b1;
      inst_ready = 1'b0;
      imem_ready = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      redirect = 1'b0;
      redirect_pc = '0;
      w_one = 1'b1;
      w_zero = 1'b0;
      w_zero32 = '0;
      w_rvalid = 1'b0;
      w_rdata = '0;

      // reset held two cycles, then stream with initial backpressure
      step();
      step();
      check("rst_inst_valid", 32'(inst_valid), 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_opcode", 32'(opcode), 0);
      check("rst_imem_req", 32'(imem_req), 0);

      tb_rst = 1'b0;
      lat = 1;
      tb_iready = 1'b0;
      tb_mready = 1'b1;
      exp_addr.push_back(32'h0);  exp_addr.push_back(32'h4);
      exp_addr.push_back(32'h8);  exp_addr.push_back(32'hC);
      expect_inst(32'h0); expect_inst(32'h4); expect_inst(32'h8); expect_inst(32'hC);
      wexp_addr.push_back(32'hFFFF_FFFC); wexp_addr.push_back(32'h0);
      wexp_pc.push_back(32'hFFFF_FFFC);   wexp_pc.push_back(32'h0);

      step();
      check("idle_no_req", 32'(imem_req), 0);
      step();
      check("first_req", 32'(imem_req), 1);
      for (int i = 0; i < 10 && !inst_valid; i++) step();
      check("fill_valid", 32'(inst_valid), 1);
      check("fill_latency", cyc - last_hs_cyc, 2);
      check("first_opcode", 32'(opcode), 32'(OP_IMM));
      for (int i = 0; i < 4; i++) begin
         check("bp_no_req", 32'(imem_req), 0);
         check("bp_inst_pc", inst_pc, 32'h0);
         check("bp_inst", inst, 32'h0050_0093);
         step();
      end
      tb_iready = 1'b1;
      step();
      t0 = last_xf_cyc;
      run_until_xfer("stream_timeout", 4, 20);
      check("throughput", last_xf_cyc - t0, 6);

      // reset while a request is outstanding
      do_reset();
      check("rstw_inst_valid", 32'(inst_valid), 0);
      check("rstw_inst", inst, 0);
      check("rstw_inst_pc", inst_pc, 0);
      check("rstw_opcode", 32'(opcode), 0);
      check("rstw_imem_req", 32'(imem_req), 0);
      check("wrap_drain", wexp_addr.size() + wexp_pc.size(), 0);

      // redirect while waiting (no response yet) -> DISCARD
      lat = 2;
      tb_iready = 1'b1;
      exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
      exp_addr.push_back(32'h8); exp_addr.push_back(32'h100);
      expect_inst(32'h0); expect_inst(32'h4); expect_inst(32'h100);
      run_until_hs_addr("b_hs8_timeout", 32'h8, 30);
      tb_redir = 1'b1;
      tb_rpc = 32'h103;
      step();
      tb_redir = 1'b0;
      step();
      check("b_redir_valid", 32'(inst_valid), 0);
      check("b_discard_req", 32'(imem_req), 0);
      run_until_xfer("b_timeout", 3, 20);

      // redirect in FETCH with the request not accepted
      do_reset();
      lat = 1;
      tb_mready = 1'b0;
      tb_redir = 1'b1;
      tb_rpc = 32'h200;
      step();
      check("c_req_stalled", 32'(imem_req), 1);
      tb_redir = 1'b0;
      step();
      check("c_req", 32'(imem_req), 1);
      check("c_addr", imem_addr, 32'h200);
      tb_mready = 1'b1;
      exp_addr.push_back(32'h200);
      expect_inst(32'h200);
      run_until_xfer("c_timeout", 1, 20);

      // redirect in FETCH with handshake, full buffer, second redirect in DISCARD
      do_reset();
      lat = 3;
      tb_iready = 1'b0;
      exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h400);
      expect_inst(32'h0); expect_inst(32'h400);
      for (int i = 0; i < 20 && !inst_valid; i++) step();
      check("d_fill", 32'(inst_valid), 1);
      tb_iready = 1'b1;
      tb_redir = 1'b1;
      tb_rpc = 32'h300;
      step();
      tb_redir = 1'b0;
      step();
      check("d_redir_valid", 32'(inst_valid), 0);
      check("d_discard_req", 32'(imem_req), 0);
      tb_redir = 1'b1;
      tb_rpc = 32'h400;
      step();
      tb_redir = 1'b0;
      step();
      check("d_discard_hold", 32'(imem_req), 0);
      step();
      check("d_req", 32'(imem_req), 1);
      check("d_addr", imem_addr, 32'h400);
      run_until_xfer("d_timeout", 2, 30);

      // redirect in WAIT coinciding with the response -> data dropped
      do_reset();
      lat = 1;
      exp_addr.push_back(32'h0); exp_addr.push_back(32'h500);
      expect_inst(32'h500);
      step();
      tb_redir = 1'b1;
      tb_rpc = 32'h500;
      step();
      tb_redir = 1'b0;
      step();
      check("e_req", 32'(imem_req), 1);
      check("e_addr", imem_addr, 32'h500);
      check("e_valid", 32'(inst_valid), 0);
      run_until_xfer("e_timeout", 1, 20);

      do_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
